sipo_loopback_harness: RTL and testbench



---
 rtl/sipo_loopback_harness.sv | 128 ++++++++++++
 tb/tb_sipo_loopback_harness.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_loopback_harness.sv
// sipo_loopback_harness
//
// Loopback test block for a serial-in/parallel-out shift register.
// A parallel word is accepted, shifted out one bit per cycle (LSB first)
// from a parallel-in/serial-out register, recaptured by a SIPO register,
// and presented again as a parallel word. Every accepted word comes back
// unchanged.
//
// Parameters
//   WIDTH      word width in bits and number of serial cycles per word (>= 2)
//
// Ports
//   clk        single clock, rising-edge active
//   rst_n      asynchronous, active-low reset
//   in_valid   load request; word taken when in_valid && in_ready at an edge
//   in_data    parallel word to send
//   in_ready   high while idle and able to take a word
//   ser_valid  high during each of the WIDTH serial bit cycles
//   ser_data   current serial bit, LSB first; 0 while idle
//   out_valid  one-cycle pulse when a complete word has been recaptured
//   out_data   last recaptured word; held until the next word completes
//
// Timing: accept at edge E0, bit i is on the line after edge E0+i, and
// out_data/out_valid update at edge E0+WIDTH together with the return to
// idle. The next word can be taken at E0+WIDTH+1.

module sipo_loopback_harness #(
  parameter int WIDTH = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             ser_valid,
  output logic             ser_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_reg;
  state_t           state_next;

  logic [WIDTH-1:0] piso_reg;
  // The final bit of a word goes straight from the serial line into
  // out_data, so the SIPO only has to remember the WIDTH-1 bits before it.
  logic [WIDTH-1:1] sipo_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic             out_valid_reg;

  logic             accept;
  logic             last_bit;

  // Next-state and combinational outputs.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    ser_valid  = 1'b0;
    ser_data   = 1'b0;
    accept     = 1'b0;
    last_bit   = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        ser_valid = 1'b1;
        ser_data  = piso_reg[0];
        // Counter value WIDTH-1 means this edge clocks in the last bit.
        if (cnt_reg == CW'(WIDTH - 1)) begin
          last_bit   = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath: PISO, SIPO, bit counter and the output word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      piso_reg      <= '0;
      sipo_reg      <= '0;
      cnt_reg       <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= last_bit;
      if (accept) begin
        piso_reg <= in_data;
        cnt_reg  <= '0;
      end else if (state_reg == SHIFT) begin
        piso_reg <= piso_reg >> 1;
        sipo_reg <= {ser_data, sipo_reg[WIDTH-1:2]};
        cnt_reg  <= cnt_reg + CW'(1);
        if (last_bit) begin
          out_data_reg <= {ser_data, sipo_reg};
        end
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

endmodule

// File: tb/tb_sipo_loopback_harness.sv
// Scoreboard bench for sipo_loopback_harness. The driver pushes the
// expected word (with its due cycle) and its serial bits into queues at
// accept time; a monitor on the falling edge pops and compares whenever
// the DUT presents out_valid or ser_valid, and checks holds otherwise.

module tb_sipo_loopback_harness;

  localparam int W = 23;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         ser_valid;
  logic         ser_data;
  logic         out_valid;
  logic [W-1:0] out_data;

  sipo_loopback_harness #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .ser_valid (ser_valid),
    .ser_data  (ser_data),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           due;
  } exp_t;

  exp_t         exp_q[$];
  logic         exp_bits[$];
  logic [W-1:0] last_out;
  int           cyc;
  int           compared;
  int           mismatched;
  int           words_ok;
  logic         mon_en;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_out_valid: got out_data %0h expected no pulse (cycle %0d)", out_data, cyc);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.data);
          check("latency", cyc, e.due);
          if (out_data === e.data) words_ok++;
          last_out = e.data;
        end
      end else begin
        check("out_hold", out_data, last_out);
      end
      if (ser_valid) begin
        check("busy_not_ready", in_ready, 0);
        if (exp_bits.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_ser_valid: got ser_valid 1 expected 0 (cycle %0d)", cyc);
        end else begin
          check("ser_bit", ser_data, exp_bits.pop_front());
        end
      end else begin
        check("ser_idle", ser_data, 0);
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic send(input logic [W-1:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      compared++;
      mismatched++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 (cycle %0d)", cyc);
    end else begin
      exp_q.push_back('{data: d, due: cyc + 1 + W});
      for (int i = 0; i < W; i++) exp_bits.push_back(d[i]);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_bits.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || exp_bits.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: got %0d words pending expected 0", exp_q.size());
      exp_q.delete();
      exp_bits.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_ser_valid"}, ser_valid, 0);
    check({tag, "_ser_data"}, ser_data, 0);
  endtask

  logic [W-1:0] directed [5];
  logic [W-1:0] mask;

  initial begin
    clk        = 1'b0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    mon_en     = 1'b0;
    cyc        = 0;
    compared   = 0;
    mismatched = 0;
    words_ok   = 0;
    last_out   = '0;
    mask       = '1;

    #2;
    check_reset_outputs("reset_async");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_release");
    mon_en = 1'b1;

    // Back-to-back directed words, then the single-bit bit-order word.
    directed[0] = 23'h000000;
    directed[1] = 23'h7FFFFF;
    directed[2] = 23'h555555;
    directed[3] = 23'h2AAAAA;
    directed[4] = 23'h000001;
    for (int i = 0; i < 5; i++) send(directed[i]);
    drain();

    // Gap and hold.
    send(23'h123456);
    drain();
    idle(10);
    check("gap_hold", out_data, 23'h123456);

    // Busy: a request during shifting must be ignored.
    send(23'h0ABCDE);
    idle(4);
    in_valid = 1'b1;
    in_data  = 23'h7FFFFF;
    idle(6);
    in_valid = 1'b0;
    drain();
    idle(W + 3);
    check("busy_result", out_data, 23'h0ABCDE);

    // Reset while bit 10 is on the line.
    send(23'h1F0F0F);
    idle(10);
    check("pre_abort_ser_valid", ser_valid, 1);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    exp_bits.delete();
    last_out = '0;
    #1;
    check_reset_outputs("reset_mid");
    idle(3);
    rst_n = 1'b1;
    idle(W + 3);
    check("abort_out_data", out_data, 0);
    send(23'h3C3C3C);
    drain();
    check("post_abort_word", out_data, 23'h3C3C3C);

    // Random words with random gaps.
    words_ok = 0;
    for (int i = 0; i < 100; i++) begin
      send(W'($urandom) & mask);
      idle($urandom_range(0, 10));
    end
    drain();
    check("random_matches", words_ok, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
